// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch controller for the SLC3 core. Sequences the PC register and the
//   MAR/MDR/IR path, handles the memory-ready handshake, and hands each fetched
//   instruction to the execute unit. Sits between top-level run control and the datapath.
//
// Parameters
//   MEM_TIMEOUT  max cycles spent in FETCH2 waiting for mem_ready before a fault
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   Clk           in   clock, all state on posedge
//   Reset_ah      in   asynchronous, active-high reset
//   Run           in   level; 1 = fetch/execute, 0 = stop at next instruction boundary
//   mem_ready     in   memory read data valid; sampled only in FETCH2
//   exec_done     in   execute finished current instruction; sampled only in EXEC
//   redirect_req  in   with exec_done: taken branch/jump, PC must be reloaded
//   redirect_src  in   0 = PC from bus, 1 = PC from offset adder
//   Continue      in   (SINGLE_STEP_EN only) rising edge releases PAUSE
//   PCMUX         out  00 = PC+1, 01 = bus, 10 = offset, 11 = hold
//   LD_PC, GatePC, LD_MAR, MIO_EN, LD_MDR, GateMDR, LD_IR
//                 out  datapath strobes, registered Moore decodes of the state
//   ir_valid      out  one-cycle pulse in the first EXEC cycle
//   mem_fault     out  sticky memory timeout flag, cleared only by reset
//   retired       out  count of exec_done acknowledges, wraps to 0
//   state         out  current FSM state encoding, for debug
//
// Configuration
//   SINGLE_STEP_EN  adds the Continue port and the PAUSE state; every instruction
//                   boundary with Run=1 parks in PAUSE until Continue rises.

module fetch_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_ah,
    input  logic             Run,
    input  logic             mem_ready,
    input  logic             exec_done,
    input  logic             redirect_req,
    input  logic             redirect_src,
`ifdef SINGLE_STEP_EN
    input  logic             Continue,
`endif
    output logic [1:0]       PCMUX,
    output logic             LD_PC,
    output logic             GatePC,
    output logic             LD_MAR,
    output logic             MIO_EN,
    output logic             LD_MDR,
    output logic             GateMDR,
    output logic             LD_IR,
    output logic             ir_valid,
    output logic             mem_fault,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StHalt   = 3'd0,
        StFetch1 = 3'd1,
        StFetch2 = 3'd2,
        StFetch3 = 3'd3,
        StExec   = 3'd4,
        StRedir  = 3'd5
`ifdef SINGLE_STEP_EN
        , StPause = 3'd6
`endif
    } state_e;

    state_e             r_state;
    logic [WaitW-1:0]   r_wait;
    logic               r_fault;
    logic [CNT_W-1:0]   r_retired;
    logic [1:0]         r_pcmux;
    logic               r_ld_pc;
    logic               r_gate_pc;
    logic               r_ld_mar;
    logic               r_mio_en;
    logic               r_ld_mdr;
    logic               r_gate_mdr;
    logic               r_ld_ir;
    logic               r_ir_valid;

    state_e             w_state_d;
    state_e             w_boundary;
    logic [WaitW-1:0]   w_wait_d;
    logic               w_fault_d;
    logic [CNT_W-1:0]   w_retired_d;
    logic [1:0]         w_pcmux_d;
    logic               w_ld_pc_d;
    logic               w_gate_pc_d;
    logic               w_ld_mar_d;
    logic               w_mio_en_d;
    logic               w_ld_mdr_d;
    logic               w_gate_mdr_d;
    logic               w_ld_ir_d;
    logic               w_ir_valid_d;

`ifdef SINGLE_STEP_EN
    logic               r_cont;
    logic               w_cont_rise;

    // Edge detect so a Continue held high releases only one instruction.
    assign w_cont_rise = Continue & ~r_cont;
    assign w_boundary  = StPause;
`else
    assign w_boundary  = StFetch1;
`endif

    // Next-state, wait counter, fault and retire bookkeeping.
    always_comb begin
        w_state_d   = r_state;
        w_wait_d    = r_wait;
        w_fault_d   = r_fault;
        w_retired_d = r_retired;
        case (r_state)
            StHalt: begin
                // A latched fault pins the sequencer here until reset.
                if (Run && !r_fault) begin
                    w_state_d = StFetch1;
                end
            end
            StFetch1: begin
                w_state_d = StFetch2;
            end
            StFetch2: begin
                // mem_ready on the last allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    w_state_d = StFetch3;
                    w_wait_d  = '0;
                end else if (r_wait == WaitLast) begin
                    w_state_d = StHalt;
                    w_fault_d = 1'b1;
                    w_wait_d  = '0;
                end else begin
                    w_wait_d = r_wait + WaitW'(1);
                end
            end
            StFetch3: begin
                w_state_d = StExec;
            end
            StExec: begin
                if (exec_done) begin
                    w_retired_d = r_retired + CNT_W'(1);
                    if (redirect_req) begin
                        w_state_d = StRedir;
                    end else if (Run) begin
                        w_state_d = w_boundary;
                    end else begin
                        w_state_d = StHalt;
                    end
                end
            end
            StRedir: begin
                w_state_d = Run ? w_boundary : StHalt;
            end
`ifdef SINGLE_STEP_EN
            StPause: begin
                if (!Run) begin
                    w_state_d = StHalt;
                end else if (w_cont_rise) begin
                    w_state_d = StFetch1;
                end
            end
`endif
            default: begin
                w_state_d = StHalt;
                w_wait_d  = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they can be registered alongside it.
    always_comb begin
        w_pcmux_d    = 2'b11;
        w_ld_pc_d    = 1'b0;
        w_gate_pc_d  = 1'b0;
        w_ld_mar_d   = 1'b0;
        w_mio_en_d   = 1'b0;
        w_ld_mdr_d   = 1'b0;
        w_gate_mdr_d = 1'b0;
        w_ld_ir_d    = 1'b0;
        case (w_state_d)
            StFetch1: begin
                w_gate_pc_d = 1'b1;
                w_ld_mar_d  = 1'b1;
                w_ld_pc_d   = 1'b1;
                w_pcmux_d   = 2'b00;
            end
            StFetch2: begin
                w_mio_en_d = 1'b1;
                w_ld_mdr_d = 1'b1;
            end
            StFetch3: begin
                w_gate_mdr_d = 1'b1;
                w_ld_ir_d    = 1'b1;
            end
            StRedir: begin
                // REDIR is only entered on exec_done, so redirect_src is captured
                // in the same cycle as the redirect request.
                w_ld_pc_d = 1'b1;
                w_pcmux_d = redirect_src ? 2'b10 : 2'b01;
            end
            default: begin
            end
        endcase
        w_ir_valid_d = (w_state_d == StExec) && (r_state == StFetch3);
    end

    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            r_state    <= StHalt;
            r_wait     <= '0;
            r_fault    <= 1'b0;
            r_retired  <= '0;
            r_pcmux    <= 2'b11;
            r_ld_pc    <= 1'b0;
            r_gate_pc  <= 1'b0;
            r_ld_mar   <= 1'b0;
            r_mio_en   <= 1'b0;
            r_ld_mdr   <= 1'b0;
            r_gate_mdr <= 1'b0;
            r_ld_ir    <= 1'b0;
            r_ir_valid <= 1'b0;
`ifdef SINGLE_STEP_EN
            r_cont     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_wait     <= w_wait_d;
            r_fault    <= w_fault_d;
            r_retired  <= w_retired_d;
            r_pcmux    <= w_pcmux_d;
            r_ld_pc    <= w_ld_pc_d;
            r_gate_pc  <= w_gate_pc_d;
            r_ld_mar   <= w_ld_mar_d;
            r_mio_en   <= w_mio_en_d;
            r_ld_mdr   <= w_ld_mdr_d;
            r_gate_mdr <= w_gate_mdr_d;
            r_ld_ir    <= w_ld_ir_d;
            r_ir_valid <= w_ir_valid_d;
`ifdef SINGLE_STEP_EN
            r_cont     <= Continue;
`endif
        end
    end

    assign PCMUX     = r_pcmux;
    assign LD_PC     = r_ld_pc;
    assign GatePC    = r_gate_pc;
    assign LD_MAR    = r_ld_mar;
    assign MIO_EN    = r_mio_en;
    assign LD_MDR    = r_ld_mdr;
    assign GateMDR   = r_gate_mdr;
    assign LD_IR     = r_ld_ir;
    assign ir_valid  = r_ir_valid;
    assign mem_fault = r_fault;
    assign retired   = r_retired;
    assign state     = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Randomized bench for fetch_sequencer. A stimulus process plays memory and execute
//   unit, pushing the expected PC-load selects, retire counts and instruction-to-
//   instruction latencies into queues; a monitor pops and compares as the DUT shows them.

module tb_fetch_sequencer;

    localparam int unsigned MemTimeout = 16;
    localparam int unsigned CntW       = 4;

    logic            Clk = 1'b0;
    logic            Reset_ah = 1'b0;
    logic            Run = 1'b0;
    logic            mem_ready = 1'b0;
    logic            exec_done = 1'b0;
    logic            redirect_req = 1'b0;
    logic            redirect_src = 1'b0;
    logic            Continue = 1'b0;
    logic [1:0]      PCMUX;
    logic            LD_PC, GatePC, LD_MAR, MIO_EN, LD_MDR, GateMDR, LD_IR;
    logic            ir_valid, mem_fault;
    logic [CntW-1:0] retired;
    logic [2:0]      state;

    fetch_sequencer #(
        .MEM_TIMEOUT(MemTimeout),
        .CNT_W      (CntW)
    ) u_dut (
        .Clk         (Clk),
        .Reset_ah    (Reset_ah),
        .Run         (Run),
        .mem_ready   (mem_ready),
        .exec_done   (exec_done),
        .redirect_req(redirect_req),
        .redirect_src(redirect_src),
`ifdef SINGLE_STEP_EN
        .Continue    (Continue),
`endif
        .PCMUX       (PCMUX),
        .LD_PC       (LD_PC),
        .GatePC      (GatePC),
        .LD_MAR      (LD_MAR),
        .MIO_EN      (MIO_EN),
        .LD_MDR      (LD_MDR),
        .GateMDR     (GateMDR),
        .LD_IR       (LD_IR),
        .ir_valid    (ir_valid),
        .mem_fault   (mem_fault),
        .retired     (retired),
        .state       (state)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_ret  = 0;
    bit lat_armed  = 1'b0;
    bit fault_test = 1'b0;
    int pc_q[$];
    int ret_q[$];
    int lat_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pcmux"}, int'(PCMUX), 3);
        chk({tag, "_strobes"},
            int'({LD_PC, GatePC, LD_MAR, MIO_EN, LD_MDR, GateMDR, LD_IR, ir_valid}), 0);
        chk({tag, "_retired"}, int'(retired), 0);
        chk({tag, "_fault"}, int'(mem_fault), 0);
    endtask

    // Monitor: everything here is compared against queued expectations.
    initial begin : monitor
        int  prev_cyc;
        bit  have_prev;
        int  last_ret;
        int  prev_state;
        have_prev  = 1'b0;
        prev_cyc   = 0;
        last_ret   = 0;
        prev_state = 0;
        forever begin
            @(negedge Clk);
            if (Reset_ah) begin
                last_ret   = int'(retired);
                have_prev  = 1'b0;
                prev_state = 0;
            end else begin
                if (!fault_test) chk("no_fault", int'(mem_fault), 0);
                if (int'(retired) != last_ret) begin
                    if (ret_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL retired_unexpected actual=%0d required=none", retired);
                    end else begin
                        chk("retired", int'(retired), ret_q.pop_front());
                    end
                    last_ret = int'(retired);
                end
                if (LD_PC) begin
                    if (pc_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL pc_load_unexpected actual=%0d required=none", PCMUX);
                    end else begin
                        chk("pcmux", int'(PCMUX), pc_q.pop_front());
                    end
                end
                if (LD_PC && PCMUX == 2'b00) begin
                    chk("fetch1_strobes", int'({GatePC, LD_MAR, MIO_EN, LD_IR}), 4'b1100);
                    if (lat_armed && have_prev) begin
                        if (lat_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL latency_unexpected actual=%0d required=none",
                                     cyc - prev_cyc);
                        end else begin
                            chk("latency", cyc - prev_cyc, lat_q.pop_front());
                        end
                    end
                    have_prev = lat_armed;
                    prev_cyc  = cyc;
                end
                if (ir_valid) chk("ir_valid_after_fetch3", prev_state * 8 + int'(state), 3 * 8 + 4);
                prev_state = int'(state);
            end
        end
    end

    // sel 0: wait for MIO_EN (FETCH2), sel 1: wait for ir_valid (first EXEC cycle).
    task automatic wait_for(input string name, input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            if ((sel == 0 && MIO_EN) || (sel == 1 && ir_valid)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s actual=timeout required=seen", name);
        end
    endtask

    task automatic start_run();
        Run = 1'b1;
        pc_q.push_back(0);
    endtask

    // One instruction: w extra memory-wait cycles, exec_done e cycles after ir_valid.
    task automatic do_instr(input int w, input int e, input bit r, input bit src,
                            input bit drop_run, input bit stop_run);
        bit ok;
        wait_for("wait_fetch2", 0, ok);
        if (!ok) return;
        if (drop_run) Run = 1'b0;
        for (int i = 0; i < w; i++) begin
            mem_ready    = 1'b0;
            exec_done    = 1'($urandom);
            redirect_req = 1'($urandom);
            @(negedge Clk);
        end
        mem_ready    = 1'b1;
        exec_done    = 1'b0;
        redirect_req = 1'b0;
        @(negedge Clk);
        mem_ready = 1'b0;
        wait_for("wait_ir_valid", 1, ok);
        if (!ok) return;
        if (stop_run) Run = 1'b0;
        for (int i = 0; i < e; i++) begin
            mem_ready    = 1'($urandom);
            redirect_req = 1'($urandom);
            redirect_src = 1'($urandom);
            @(negedge Clk);
        end
        mem_ready    = 1'b0;
        exec_done    = 1'b1;
        redirect_req = r;
        redirect_src = src;
        exp_ret = (exp_ret + 1) % (1 << CntW);
        ret_q.push_back(exp_ret);
        if (r) pc_q.push_back(src ? 2 : 1);
        if (Run) begin
            pc_q.push_back(0);
            if (lat_armed) lat_q.push_back(w + e + 4 + (r ? 1 : 0));
        end
        @(negedge Clk);
        exec_done    = 1'b0;
        redirect_req = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge Clk);
        #2 Reset_ah = 1'b1;
        Run = 1'b0;
        #1 chk_idle(tag);
        exp_ret = 0;
        @(negedge Clk);
        #2 Reset_ah = 1'b0;
    endtask

    initial begin : stim
        int  cnt;
        bit  ok;
        int  n;
        #2 Reset_ah = 1'b1;
        #1 chk_idle("reset");
        @(negedge Clk);
        #2 Reset_ah = 1'b0;
        @(negedge Clk);
        chk("halt_without_run", int'(state), 0);

        // Free-running stream: three nominal instructions, then randomized ones.
        lat_armed = 1'b1;
        start_run();
        n = 24;
        for (int k = 0; k < n; k++) begin
            int w, e;
            bit r, src;
            if (k < 3) begin
                w = 0; e = 1; r = 1'b0; src = 1'b0;
            end else if (k == 5) begin
                w = MemTimeout - 1; e = 0; r = 1'b1; src = 1'b1;
            end else begin
                w   = $urandom_range(0, MemTimeout - 1);
                e   = $urandom_range(0, 4);
                r   = ($urandom_range(0, 2) == 0);
                src = 1'($urandom);
            end
            do_instr(w, e, r, src, 1'b0, k == n - 1);
        end
        lat_armed = 1'b0;
        repeat (4) @(negedge Clk);
        chk("halt_after_stream", int'(state), 0);

        // Run dropped during FETCH2: instruction completes, then HALT; resume cleanly.
        start_run();
        do_instr(3, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge Clk);
        chk("halt_after_drop", int'(state), 0);
        start_run();
        do_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_instr(MemTimeout - 1, 1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge Clk);
        chk("halt_after_redirect", int'(state), 0);

        // Memory timeout: fault after MemTimeout cycles in FETCH2, then sticky HALT.
        fault_test = 1'b1;
        start_run();
        wait_for("wait_fetch2_fault", 0, ok);
        mem_ready = 1'b0;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (mem_fault) break;
            cnt++;
        end
        chk("timeout_cycles", cnt, MemTimeout);
        chk("fault_state", int'(state), 0);
        for (int i = 0; i < 8; i++) begin
            Run = 1'($urandom);
            @(negedge Clk);
            chk("fault_pinned", int'(state), 0);
            chk("fault_sticky", int'(mem_fault), 1);
        end
        pulse_reset("fault_reset");
        fault_test = 1'b0;

        // Asynchronous reset in the middle of EXEC.
        start_run();
        do_instr(1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge Clk);
        start_run();
        wait_for("wait_fetch2_rst", 0, ok);
        mem_ready = 1'b1;
        @(negedge Clk);
        mem_ready = 1'b0;
        wait_for("wait_ir_valid_rst", 1, ok);
        chk("exec_before_reset", int'(state), 4);
        pulse_reset("exec_reset");
        repeat (3) @(negedge Clk);

        chk("pc_queue_drained", pc_q.size(), 0);
        chk("ret_queue_drained", ret_q.size(), 0);
        chk("lat_queue_drained", lat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
